// File: rtl/converter_supervisor_pkg.sv
// rtl/converter_supervisor_pkg.sv - shared encodings and fault classifier for the converter supervisor
// Contents: FSM state codes, gate-mode codes, fault codes, default timing/threshold values,
//           gate-mode decode per state and the prioritised fault classifier.
package converter_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BOOT  = 3'd1,
    ST_PRECH = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4,
    ST_COOL  = 3'd5,
    ST_LOCK  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    GM_OFF   = 2'b00,
    GM_BOOT  = 2'b01,
    GM_FORCE = 2'b10,
    GM_RUN   = 2'b11
  } gate_mode_t;

  typedef enum logic [2:0] {
    FC_NONE   = 3'd0,
    FC_SHORT  = 3'd1,
    FC_OV     = 3'd2,
    FC_OC     = 3'd3,
    FC_NOLOAD = 3'd4
  } fault_code_t;

  localparam logic [15:0] DEF_T_BOOT    = 16'd10;
  localparam logic [15:0] DEF_T_PRECH   = 16'd4;
  localparam logic [15:0] DEF_T_SETTLE  = 16'd500;
  localparam logic [15:0] DEF_T_COOL    = 16'd1000;
  localparam logic [1:0]  DEF_MAX_RETRY = 2'd3;
  localparam logic [7:0]  DEF_V_OV      = 8'd50;
  localparam logic [7:0]  DEF_V_MIN     = 8'd5;
  localparam logic [7:0]  DEF_I_MAX     = 8'd60;

  function automatic gate_mode_t gate_for(input state_t s);
    gate_mode_t g;
    case (s)
      ST_BOOT:  g = GM_BOOT;
      ST_PRECH: g = GM_FORCE;
      ST_RUN:   g = GM_RUN;
      default:  g = GM_OFF;
    endcase
    return g;
  endfunction

  // Highest-priority active fault: SHORT > OV > OC > NOLOAD.
  function automatic fault_code_t detect_fault(
    input logic       short_det,
    input logic [7:0] vbat,
    input logic [7:0] ibat,
    input logic       oc_en,
    input logic       pi_en,
    input logic [7:0] v_ov,
    input logic [7:0] v_min,
    input logic [7:0] i_max
  );
    fault_code_t f;
    if (short_det)                     f = FC_SHORT;
    else if (vbat > v_ov)              f = FC_OV;
    else if (oc_en && (ibat > i_max))  f = FC_OC;
    else if (pi_en && (vbat < v_min))  f = FC_NOLOAD;
    else                               f = FC_NONE;
    return f;
  endfunction

endpackage

// File: rtl/converter_supervisor_if.sv
// rtl/converter_supervisor_if.sv - supervisor control/status bundle
// Inputs to supervisor: tick, enable, clear, cross_short, vbat_dec, ibat_dec
// Outputs from supervisor: gate_mode, ctrl_rst, pi_en, fault, fault_code, retry_cnt, state
interface converter_supervisor_if;
  logic       tick;
  logic       enable;
  logic       clear;
  logic       cross_short;
  logic [7:0] vbat_dec;
  logic [7:0] ibat_dec;
  logic [1:0] gate_mode;
  logic       ctrl_rst;
  logic       pi_en;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  modport master (
    output tick, enable, clear, cross_short, vbat_dec, ibat_dec,
    input  gate_mode, ctrl_rst, pi_en, fault, fault_code, retry_cnt, state
  );

  modport slave (
    input  tick, enable, clear, cross_short, vbat_dec, ibat_dec,
    output gate_mode, ctrl_rst, pi_en, fault, fault_code, retry_cnt, state
  );
endinterface

// File: rtl/converter_supervisor_timer.sv
// rtl/converter_supervisor_timer.sv - 16-bit tick counter with clear, saturation and limit compare
// Ports: clk_100M, rst (sync, active-high), clr (restart count), tick (1 us strobe),
//        limit (ticks for the current state), expire (pulse on the limit-th tick)
module supervisor_timer (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        clr,
  input  logic        tick,
  input  logic [15:0] limit,
  output logic        expire
);

  logic [15:0] count;

  always_ff @(posedge clk_100M) begin
    if (rst || clr) begin
      count <= 16'd0;
    end else if (tick && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  // Fires on the cycle carrying the limit-th tick so the owner can leave
  // on the same edge that would have counted it.
  assign expire = tick && (count == (limit - 16'd1));

endmodule

// File: rtl/converter_supervisor.sv
// rtl/converter_supervisor.sv - start-up, protection and restart sequencer for the resonant converter
// Ports: clk_100M, rst (sync, active-high), bus (slave side of converter_supervisor_if):
//        tick/enable/clear/cross_short/vbat_dec/ibat_dec in;
//        gate_mode/ctrl_rst/pi_en/fault/fault_code/retry_cnt/state out (all registered)
module converter_supervisor
  import converter_supervisor_pkg::*;
#(
  parameter logic [15:0] T_BOOT    = DEF_T_BOOT,
  parameter logic [15:0] T_PRECH   = DEF_T_PRECH,
  parameter logic [15:0] T_SETTLE  = DEF_T_SETTLE,
  parameter logic [15:0] T_COOL    = DEF_T_COOL,
  parameter logic [1:0]  MAX_RETRY = DEF_MAX_RETRY,
  parameter logic [7:0]  V_OV      = DEF_V_OV,
  parameter logic [7:0]  V_MIN     = DEF_V_MIN,
  parameter logic [7:0]  I_MAX     = DEF_I_MAX
) (
  input  logic                   clk_100M,
  input  logic                   rst,
  converter_supervisor_if.slave  bus
);

  state_t      state_q, state_d;
  fault_code_t code_q, code_d;
  fault_code_t det;
  gate_mode_t  gate_q;
  logic [1:0]  retry_q, retry_d;
  logic        pi_en_q, pi_en_d;
  logic        ctrl_rst_q;
  logic        fault_q;
  logic [15:0] limit;
  logic        expire;
  logic        active;

  supervisor_timer u_timer (
    .clk_100M (clk_100M),
    .rst      (rst),
    .clr      (state_d != state_q),
    .tick     (bus.tick),
    .limit    (limit),
    .expire   (expire)
  );

  always_comb begin
    limit = 16'd0;
    case (state_q)
      ST_BOOT:  limit = T_BOOT;
      ST_PRECH: limit = T_PRECH;
      ST_RUN:   limit = T_SETTLE;
      ST_COOL:  limit = T_COOL;
      default:  limit = 16'd0;
    endcase
  end

  assign active = (state_q == ST_BOOT) || (state_q == ST_PRECH) || (state_q == ST_RUN);
  assign det    = detect_fault(bus.cross_short, bus.vbat_dec, bus.ibat_dec,
                               state_q == ST_RUN, pi_en_q, V_OV, V_MIN, I_MAX);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    retry_d = retry_q;
    pi_en_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_BOOT;
          code_d  = FC_NONE;
        end
      end
      ST_BOOT: begin
        if (expire) state_d = ST_PRECH;
      end
      ST_PRECH: begin
        if (expire) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Surviving the settle window counts as a clean start: forget history.
        pi_en_d = pi_en_q || expire;
        if (expire) begin
          code_d  = FC_NONE;
          retry_d = 2'd0;
        end
      end
      ST_FAULT: begin
        // retry_q already holds the count incremented on entry to FAULT.
        state_d = (retry_q == MAX_RETRY) ? ST_LOCK : ST_COOL;
      end
      ST_COOL: begin
        if (expire) state_d = bus.enable ? ST_BOOT : ST_IDLE;
      end
      ST_LOCK: begin
        if (bus.clear && !bus.enable) begin
          state_d = ST_IDLE;
          code_d  = FC_NONE;
          retry_d = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (active && (det != FC_NONE)) begin
      state_d = ST_FAULT;
      code_d  = det;
      retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
      pi_en_d = 1'b0;
    end

    // Enable drop outranks a same-cycle fault: the code stays latched but the
    // fault is not counted against the retry budget.
    if ((active || (state_q == ST_COOL)) && !bus.enable) begin
      state_d = ST_IDLE;
      retry_d = 2'd0;
      pi_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= FC_NONE;
      retry_q    <= 2'd0;
      pi_en_q    <= 1'b0;
      gate_q     <= GM_OFF;
      ctrl_rst_q <= 1'b1;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      retry_q    <= retry_d;
      pi_en_q    <= pi_en_d;
      gate_q     <= gate_for(state_d);
      ctrl_rst_q <= (state_d != ST_RUN);
      fault_q    <= (code_d != FC_NONE);
    end
  end

  assign bus.state      = state_q;
  assign bus.gate_mode  = gate_q;
  assign bus.ctrl_rst   = ctrl_rst_q;
  assign bus.pi_en      = pi_en_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.retry_cnt  = retry_q;

endmodule

// File: doc/converter_supervisor.md
Name: converter_supervisor

Overview:
Start-up, protection and restart sequencer for the full-bridge resonant converter. It replaces the ad-hoc bootstrap counter and OV/restart logic in the top level with a single FSM. The FSM selects the gate mode fed to the Q[3:0] mux, holds the hybrid controller and PI in reset until the tank is running, and latches faults with bounded auto-retry. It runs on clk_100M and counts time in 1 us ticks supplied from the clk_1M domain as a synchronised single-cycle strobe.

Parameters:
T_BOOT, 10, bootstrap-charge duration in ticks (low-side Q3/Q4 on)
T_PRECH, 4, forced sigma=1 duration in ticks (Q1/Q4 on)
T_SETTLE, 500, ticks in RUN before PI enable and no-load check
T_COOL, 1000, off time in ticks before an auto-retry
MAX_RETRY, 3, consecutive faults allowed before lockout
V_OV, 50, over-voltage threshold, Vbat in V (strictly greater trips)
V_MIN, 5, no-load threshold, Vbat in V (strictly less trips, after settle)
I_MAX, 60, over-current threshold, Ibat in dA (strictly greater trips)

Ports:
i_CLK  in  1  system clock (clk_100M)
i_RST  in  1  synchronous reset, active-high
i_tick  in  1  1 us strobe, one i_CLK cycle wide
i_enable  in  1  converter enable (debounced sw[0])
i_clear  in  1  fault-lockout clear (debounced button)
i_short  in  1  1 = cross-conduction detected on the Q1..Q4 requests
i_Vbat_dec  in  8  battery voltage, V, unsigned
i_Ibat_dec  in  8  battery current, dA, unsigned
o_gate_mode  out  2  00 OFF, 01 BOOT (Q3,Q4), 10 FORCE (Q1,Q4), 11 RUN (controller)
o_ctrl_rst  out  1  1 = hold hybrid controller and PI in reset
o_pi_en  out  1  1 = PI closed loop allowed
o_fault  out  1  1 = fault code latched and non-zero
o_fault_code  out  3  0 none, 1 SHORT, 2 OV, 3 OC, 4 NOLOAD
o_retry_cnt  out  2  consecutive faults since last clear
o_state  out  3  current FSM state, for debug display

Behaviour:
- All outputs are registered and change on the clock edge after the state/timer update.
- Reset values: state IDLE, gate OFF, ctrl_rst 1, pi_en 0, fault 0, code 0, retry 0, timer 0.
- States: IDLE=0, BOOT=1, PRECH=2, RUN=3, FAULT=4, COOL=5, LOCK=6.
- Timer: 16-bit, increments on i_tick, cleared on every state change. A timed state exits on the edge that samples the T-th i_tick counted in that state. The timer saturates at 0xFFFF and does not wrap.
- IDLE: gate OFF. If i_enable=1, go to BOOT.
- BOOT: gate BOOT for T_BOOT ticks, then go to PRECH.
- PRECH: gate FORCE for T_PRECH ticks, then go to RUN.
- RUN: gate RUN. o_ctrl_rst=0 from the first RUN cycle. o_pi_en=1 once the timer reaches T_SETTLE; it stays 1 while in RUN.
- o_ctrl_rst=1 in every state except RUN.
- Fault detection in BOOT, PRECH and RUN:
  - SHORT: i_short=1.
  - OV: Vbat > V_OV.
  - OC: Ibat > I_MAX (RUN only).
  - NOLOAD: Vbat < V_MIN with pi_en=1.
  - Priority when several are true: SHORT > OV > OC > NOLOAD. The highest is latched into o_fault_code and the FSM goes to FAULT.
- FAULT: one cycle, gate OFF, retry_cnt increments. Next state is LOCK if the new count equals MAX_RETRY, else COOL.
- COOL: gate OFF for T_COOL ticks, then go to BOOT if i_enable=1, else IDLE. o_fault_code stays latched until the next clean entry to RUN lasting T_SETTLE. At that point code is cleared and retry_cnt is cleared.
- LOCK: gate OFF. Ignores i_enable. Leaves only on i_clear=1 with i_enable=0, going to IDLE and clearing code and retry_cnt.
- i_enable=0 in BOOT, PRECH, RUN or COOL forces IDLE on the next edge. This takes priority over a same-cycle fault: the code is still latched, retry_cnt is not incremented.
- IDLE entry from an enable drop clears retry_cnt but keeps the code. The code is cleared on the next transition from IDLE to BOOT.
- i_RST mid-operation: reset values on the next edge, gate OFF immediately at that edge.
- Gate mode never goes straight from BOOT to RUN. Every path into RUN passes through PRECH.

Decomposition:
- Package converter_supervisor_pkg: state encodings, gate-mode codes (GM_OFF/GM_BOOT/GM_FORCE/GM_RUN), fault codes (FC_NONE..FC_NOLOAD).
- Sub-module supervisor_timer: 16-bit tick counter with clear, saturation and a compare output against a parameter-selected limit.

Test Plan:
- Bench uses i_tick every 100 cycles. Assert enable -> BOOT for 10 ticks, PRECH for 4 ticks, RUN; ctrl_rst falls on RUN entry; pi_en rises after 500 ticks; Vbat=24 gives no fault.
- In RUN after settle, Vbat=51 -> code 2, gate OFF within 2 cycles, COOL 1000 ticks, then BOOT; Vbat=50 must not trip.
- Drive i_short=1 and Vbat=60 in the same cycle during BOOT -> code 1 (SHORT wins), retry_cnt=1.
- Force OC (Ibat=61) three times in a row -> retry 1, 2, 3; third fault enters LOCK. Enable toggling is ignored. i_clear with enable=1 is ignored. i_clear with enable=0 -> IDLE, code 0, retry 0.
- Vbat=3 during PRECH and early RUN -> no fault; still 3 when pi_en rises -> NOLOAD, code 4.
- Drop enable in RUN on the same cycle as OV -> IDLE, code 2, retry_cnt 0. Pulse i_RST in PRECH -> all outputs at reset values next cycle.
